// File: rtl/wm_program_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wm_program_ctrl
// Brief    : Washing-machine program controller. Runs fill, detergent, soap
//            wash, NUM_RINSES rinse cycles and spin, with internal phase
//            timers, fill/drain watchdogs and a sticky door-open fault.
//            Optional pause/resume of the motor phases is compiled in when
//            the macro WM_PAUSE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module wm_program_ctrl #(
    parameter int TIMER_W       = 16,
    parameter int WASH_TICKS    = 1000,
    parameter int RINSE_TICKS   = 500,
    parameter int SPIN_TICKS    = 800,
    parameter int NUM_RINSES    = 2,
    parameter int FILL_TIMEOUT  = 2000,
    parameter int DRAIN_TIMEOUT = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_close,
    input  logic       start,
    input  logic       filled,
    input  logic       detergent_added,
    input  logic       drained,
    input  logic       pause,
    output logic       door_lock,
    output logic       motor_on,
    output logic       fill_valve_on,
    output logic       drain_valve_on,
    output logic       soap_wash,
    output logic       water_wash,
    output logic       done,
    output logic       fault,
    output logic [3:0] rinse_count,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FILL      = 4'd1,
        S_DETERGENT = 4'd2,
        S_WASH      = 4'd3,
        S_DRAIN     = 4'd4,
        S_RINSE     = 4'd5,
        S_SPIN      = 4'd6,
        S_DONE      = 4'd7,
        S_FAULT     = 4'd8,
        S_PAUSED    = 4'd9
    } state_t;

    // Last tick value of each timed state / watchdog window
    localparam logic [TIMER_W-1:0] c_wash_last  = TIMER_W'(WASH_TICKS - 1);
    localparam logic [TIMER_W-1:0] c_rinse_last = TIMER_W'(RINSE_TICKS - 1);
    localparam logic [TIMER_W-1:0] c_spin_last  = TIMER_W'(SPIN_TICKS - 1);
    localparam logic [TIMER_W-1:0] c_fill_last  = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] c_drain_last = TIMER_W'(DRAIN_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next;
    logic [TIMER_W-1:0]   r_tick;
    logic [3:0]           r_rinse_count;
    logic                 r_phase;
    logic [4:0]           w_rinse_next;
    logic                 w_more_rinses;

`ifdef WM_PAUSE_EN
    state_t               r_saved;
`else
    logic                 w_pause_unused;
    assign w_pause_unused = pause;
`endif

    // Rinse count as it will stand after the current drain completes; a
    // drain in the rinse phase is always the tail of a rinse.
    assign w_rinse_next  = {1'b0, r_rinse_count} + 5'd1;
    assign w_more_rinses = r_phase ? (w_rinse_next < 5'(NUM_RINSES))
                                   : (NUM_RINSES != 0);

    // Next-state decode: door fault first, then sensor/timer completion,
    // then watchdog or pause request
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && door_close) w_next = S_FILL;
            end
            S_FILL: begin
                if (!door_close)                w_next = S_FAULT;
                else if (filled)                w_next = r_phase ? S_RINSE : S_DETERGENT;
                else if (r_tick == c_fill_last) w_next = S_FAULT;
            end
            S_DETERGENT: begin
                if (!door_close)          w_next = S_FAULT;
                else if (detergent_added) w_next = S_WASH;
            end
            S_WASH: begin
                if (!door_close)                w_next = S_FAULT;
                else if (r_tick == c_wash_last) w_next = S_DRAIN;
`ifdef WM_PAUSE_EN
                else if (pause)                 w_next = S_PAUSED;
`endif
            end
            S_RINSE: begin
                if (!door_close)                 w_next = S_FAULT;
                else if (r_tick == c_rinse_last) w_next = S_DRAIN;
`ifdef WM_PAUSE_EN
                else if (pause)                  w_next = S_PAUSED;
`endif
            end
            S_SPIN: begin
                if (!door_close)                w_next = S_FAULT;
                else if (r_tick == c_spin_last) w_next = S_DONE;
`ifdef WM_PAUSE_EN
                else if (pause)                 w_next = S_PAUSED;
`endif
            end
            S_DRAIN: begin
                if (!door_close)                 w_next = S_FAULT;
                else if (drained)                w_next = w_more_rinses ? S_FILL : S_SPIN;
                else if (r_tick == c_drain_last) w_next = S_FAULT;
            end
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_FAULT;
`ifdef WM_PAUSE_EN
            S_PAUSED: begin
                if (!door_close) w_next = S_FAULT;
                else if (!pause) w_next = r_saved;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // State, tick counter, rinse bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_tick        <= '0;
            r_rinse_count <= 4'd0;
            r_phase       <= 1'b0;
`ifdef WM_PAUSE_EN
            r_saved       <= S_IDLE;
`endif
        end else begin
            r_state <= w_next;

`ifdef WM_PAUSE_EN
            // The cycle on which pause is sampled still counts as a run
            // tick, so the counter advances into PAUSED and then freezes
            // until the saved state is resumed.
            if (w_next == S_PAUSED && r_state != S_PAUSED) begin
                r_saved <= r_state;
                r_tick  <= r_tick + TIMER_W'(1);
            end else if (r_state == S_PAUSED) begin
                r_tick  <= r_tick;
            end else if (w_next == r_state) begin
                r_tick  <= r_tick + TIMER_W'(1);
            end else begin
                r_tick  <= '0;
            end
`else
            if (w_next == r_state) r_tick <= r_tick + TIMER_W'(1);
            else                   r_tick <= '0;
`endif

            if (r_state == S_IDLE) begin
                r_rinse_count <= 4'd0;
                r_phase       <= 1'b0;
            end else if (r_state == S_DRAIN && (w_next == S_FILL || w_next == S_SPIN)) begin
                if (r_phase)           r_rinse_count <= r_rinse_count + 4'd1;
                if (w_next == S_FILL)  r_phase       <= 1'b1;
            end
        end
    end

    // Moore outputs decoded from registered state only
    assign door_lock      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign motor_on       = (r_state == S_WASH) || (r_state == S_RINSE) || (r_state == S_SPIN);
    assign fill_valve_on  = (r_state == S_FILL);
    assign drain_valve_on = (r_state == S_DRAIN) || (r_state == S_SPIN);
    assign soap_wash      = (r_state == S_DETERGENT) || (r_state == S_WASH) ||
                            ((r_state == S_DRAIN) && !r_phase);
    assign water_wash     = r_phase && ((r_state == S_FILL) || (r_state == S_RINSE) ||
                                        (r_state == S_DRAIN));
    assign done           = (r_state == S_DONE);
    assign fault          = (r_state == S_FAULT);
    assign rinse_count    = r_rinse_count;
    assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_wm_program_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wm_program_ctrl
// Brief    : Self-checking bench for wm_program_ctrl: behavioural program
//            model compared every cycle, directed scenarios with literal
//            expectations, then randomized sensor/panel stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wm_program_ctrl;

    localparam int WASH_T = 4, RINSE_T = 3, SPIN_T = 5, NRINSE = 2;
    localparam int FILL_TO = 8, DRAIN_TO = 8;
`ifdef WM_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0, door_close = 1'b0, start = 1'b0, filled = 1'b0;
    logic detergent_added = 1'b0, drained = 1'b0, pause = 1'b0;
    logic door_lock, motor_on, fill_valve_on, drain_valve_on;
    logic soap_wash, water_wash, done, fault;
    logic [3:0] rinse_count, state;

    wm_program_ctrl #(
        .TIMER_W(16), .WASH_TICKS(WASH_T), .RINSE_TICKS(RINSE_T),
        .SPIN_TICKS(SPIN_T), .NUM_RINSES(NRINSE),
        .FILL_TIMEOUT(FILL_TO), .DRAIN_TIMEOUT(DRAIN_TO)
    ) dut (
        .clk(clk), .reset(reset), .door_close(door_close), .start(start),
        .filled(filled), .detergent_added(detergent_added), .drained(drained),
        .pause(pause), .door_lock(door_lock), .motor_on(motor_on),
        .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
        .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
        .fault(fault), .rinse_count(rinse_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_print  = 0;
    bit auto_en  = 1'b0;

    // ---------------- behavioural model ----------------
    // m_st uses the published state numbers; m_el = cycles already spent in it
    int m_st = 0, m_el = 0, m_rc = 0, m_ph = 0, m_saved = 0, m_saved_el = 0;
    int m_nx;
    bit m_valid = 1'b0;

    function automatic int duration(input int s);
        case (s)
            3:       return WASH_T;
            5:       return RINSE_T;
            default: return SPIN_T;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_st = 0; m_el = 0; m_rc = 0; m_ph = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_nx = m_st;
            if (m_st != 0 && m_st != 7 && m_st != 8 && !door_close) begin
                m_nx = 8;
            end else begin
                case (m_st)
                    0: begin
                        m_rc = 0; m_ph = 0;
                        if (start && door_close) m_nx = 1;
                    end
                    1: if (filled) m_nx = (m_ph != 0) ? 5 : 2;
                       else if (m_el + 1 >= FILL_TO) m_nx = 8;
                    2: if (detergent_added) m_nx = 3;
                    3, 5, 6: if (m_el + 1 >= duration(m_st)) m_nx = (m_st == 6) ? 7 : 4;
                             else if (PAUSE_EN && pause) m_nx = 9;
                    4: if (drained) begin
                           if (m_ph != 0) m_rc = m_rc + 1;
                           if (m_rc < NRINSE) begin m_nx = 1; m_ph = 1; end
                           else m_nx = 6;
                       end else if (m_el + 1 >= DRAIN_TO) m_nx = 8;
                    7: m_nx = 0;
                    9: if (!pause) m_nx = m_saved;
                    default: m_nx = 8;
                endcase
            end
            if (m_nx == 9 && m_st != 9) begin
                m_saved = m_st; m_saved_el = m_el + 1; m_el = 0;
            end else if (m_st == 9) begin
                m_el = (m_nx == 9) ? 0 : m_saved_el;
            end else begin
                m_el = (m_nx == m_st) ? m_el + 1 : 0;
            end
            m_st = m_nx;
        end
    end

    function automatic logic [15:0] model_out();
        logic lk, mo, fv, dv, sw, ww, dn, ft;
        lk = !(m_st == 0 || m_st == 7);
        mo = (m_st == 3 || m_st == 5 || m_st == 6);
        fv = (m_st == 1);
        dv = (m_st == 4 || m_st == 6);
        sw = (m_st == 2 || m_st == 3 || (m_st == 4 && m_ph == 0));
        ww = (m_ph != 0) && (m_st == 1 || m_st == 5 || m_st == 4);
        dn = (m_st == 7);
        ft = (m_st == 8);
        return {lk, mo, fv, dv, sw, ww, dn, ft, 4'(m_rc), 4'(m_st)};
    endfunction

    wire [15:0] dut_out = {door_lock, motor_on, fill_valve_on, drain_valve_on,
                           soap_wash, water_wash, done, fault, rinse_count, state};

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            n_checks = n_checks + 1;
            if (dut_out !== model_out()) begin
                n_fail = n_fail + 1;
                if (n_print < 20) begin
                    n_print = n_print + 1;
                    $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, dut_out, model_out());
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (auto_en) begin
            filled          = (m_st == 1 && m_el >= 1);
            detergent_added = (m_st == 2 && m_el >= 1);
            drained         = (m_st == 4 && m_el >= 1);
        end
    endtask

    task automatic wait_model(input int s, input int budget);
        int n;
        n = 0;
        while (m_st != s && n < budget) begin step(); n++; end
        check($sformatf("reach_state_%0d", s), m_st, s);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; pause = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int trace[$];
        int runs[$];
        int exp_trace[14] = '{0,1,2,3,4,1,5,4,1,5,4,6,7,0};
        int exp_runs[4]   = '{4,3,3,5};
        int run_len, done_cnt, rc_at_done, motor_cnt, paused_cnt;

        // Reset state
        door_close = 1'b1;
        do_reset();
        check("reset_outputs", int'(dut_out), 0);

        // 1. Full program with sensors 2 cycles after entry
        auto_en = 1'b1;
        trace.push_back(int'(state));
        run_len = 0; done_cnt = 0; rc_at_done = -1;
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            if (int'(state) != trace[$]) trace.push_back(int'(state));
            if (motor_on) run_len++;
            else if (run_len != 0) begin runs.push_back(run_len); run_len = 0; end
            if (done) begin done_cnt++; rc_at_done = int'(rinse_count); end
            step();
        end
        check("s1_trace_len", trace.size(), 14);
        for (int i = 0; i < 14; i++)
            check($sformatf("s1_trace_%0d", i), (i < trace.size()) ? trace[i] : -1, exp_trace[i]);
        check("s1_motor_runs", runs.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("s1_motor_run_%0d", i), (i < runs.size()) ? runs[i] : -1, exp_runs[i]);
        check("s1_rinse_count", rc_at_done, 2);
        check("s1_done_cycles", done_cnt, 1);

        // 2. Fill watchdog
        auto_en = 1'b0; filled = 1'b0; detergent_added = 1'b0; drained = 1'b0;
        do_reset();
        pulse_start();
        check("s2_fill_entry", int'(state), 1);
        repeat (7) step();
        check("s2_fill_last_cycle", int'(state), 1);
        step();
        check("s2_fault_state", int'(state), 8);
        check("s2_fault_flag", int'(fault), 1);
        check("s2_door_lock", int'(door_lock), 1);
        start = 1'b1;
        repeat (5) step();
        start = 1'b0;
        check("s2_sticky", int'(state), 8);

        // 3. Door opened on WASH cycle 2
        do_reset();
        auto_en = 1'b1;
        pulse_start();
        wait_model(3, 50);
        step(); step();
        door_close = 1'b0;
        step();
        check("s3_fault_state", int'(state), 8);
        check("s3_motor_off", int'(motor_on), 0);
        door_close = 1'b1;

        // 4. filled on the watchdog cycle wins
        auto_en = 1'b0; filled = 1'b0;
        do_reset();
        pulse_start();
        repeat (7) step();
        filled = 1'b1;
        step();
        filled = 1'b0;
        check("s4_to_detergent", int'(state), 2);
        check("s4_no_fault", int'(fault), 0);

        // 5. Reset during SPIN, then a clean program
        do_reset();
        auto_en = 1'b1;
        pulse_start();
        wait_model(6, 100);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("s5_reset_state", int'(state), 0);
        check("s5_reset_outputs", int'(dut_out), 0);
        pulse_start();
        wait_model(7, 100);
        check("s5_done", int'(done), 1);

`ifdef WM_PAUSE_EN
        // 6. Pause 6 cycles from WASH tick 1
        do_reset();
        pulse_start();
        wait_model(3, 50);
        motor_cnt = 0; paused_cnt = 0;
        motor_cnt += int'(motor_on);
        step();
        motor_cnt += int'(motor_on);
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 5) pause = 1'b0;
            if (state == 4'd4) break;
            motor_cnt  += int'(motor_on);
            paused_cnt += int'(state == 4'd9);
        end
        check("s6_paused_cycles", paused_cnt, 6);
        check("s6_motor_cycles", motor_cnt, 4);
`endif

        // Randomized stimulus against the model
        auto_en = 1'b0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            door_close      = ($urandom_range(0, 249) != 0);
            start           = ($urandom_range(0, 3) == 0);
            filled          = ($urandom_range(0, 3) == 0);
            detergent_added = ($urandom_range(0, 2) == 0);
            drained         = ($urandom_range(0, 3) == 0);
            pause           = ($urandom_range(0, 4) == 0);
            reset           = (m_st == 8) ? ($urandom_range(0, 15) == 0)
                                          : ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
